// File: rtl/display_arbiter.sv
// Round-robin arbiter that lets several requesters share one seven-segment
// display. An owner keeps the display for at least DWELL_CYCLES cycles
// while others are waiting. If the owner drops its request, the next waiting
// requester gets the display at once.
//
// Ports:
//   clock        - single clock, rising edge
//   reset        - asynchronous, active-high reset
//   request      - per-requester request level
//   dataIn       - requester i hex digits at [16i+15:16i]
//   pointIn      - requester i decimal-point mask at [4i+3:4i]
//   grant        - one-hot owner, zero when idle (registered)
//   data         - owner digit data, zero when idle (registered)
//   pointEnable  - owner decimal-point mask, zero when idle (registered)
//   busy         - high while the display is owned (registered)
module display_arbiter #(
  parameter int unsigned REQUESTERS   = 4,
  parameter int unsigned DWELL_CYCLES = 50000000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [REQUESTERS-1:0]        request,
  input  logic [16*REQUESTERS-1:0]     dataIn,
  input  logic [4*REQUESTERS-1:0]      pointIn,
  output logic [REQUESTERS-1:0]        grant,
  output logic [15:0]                  data,
  output logic [3:0]                   pointEnable,
  output logic                         busy
);

  localparam int unsigned IW = $clog2(REQUESTERS);
  localparam int unsigned CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(REQUESTERS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_OWNED
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           own_q, own_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [REQUESTERS-1:0]   grant_q, grant_d;
  logic [15:0]             data_q, data_d;
  logic [3:0]              point_q, point_d;
  logic                    busy_q, busy_d;

  logic                    take;
  logic [IW-1:0]           next_idx;
  logic [REQUESTERS-1:0]   others;
  logic                    dwell_done;

  // First set bit of mask, searching upward from start with wrap-around.
  function automatic logic [IW-1:0] pick(input logic [REQUESTERS-1:0] mask,
                                         input logic [IW-1:0]         start);
    logic [IW-1:0] res;
    logic [IW-1:0] jj;
    logic          hit;
    int unsigned   j;
    res = '0;
    hit = 1'b0;
    for (int unsigned k = 0; k < REQUESTERS; k++) begin
      j  = (32'(start) + k) % REQUESTERS;
      jj = IW'(j);
      if (!hit && mask[jj]) begin
        hit = 1'b1;
        res = jj;
      end
    end
    return res;
  endfunction

  // State register plus registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      own_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      point_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      point_q <= point_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and output logic; the defaults describe the idle display.
  always_comb begin
    state_d  = ST_IDLE;
    own_d    = own_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    grant_d  = '0;
    data_d   = '0;
    point_d  = '0;
    busy_d   = 1'b0;
    take     = 1'b0;
    next_idx = '0;
    // grant_q is zero when idle, so this is the full request vector then.
    others     = request & ~grant_q;
    dwell_done = (cnt_q == DWELL_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (|request) begin
          take     = 1'b1;
          next_idx = pick(request, ptr_q);
        end
      end
      ST_OWNED: begin
        if (!request[own_q] || (dwell_done && |others)) begin
          // Owner leaving or dwell expired under contention.
          if (|others) begin
            take     = 1'b1;
            next_idx = pick(others, ptr_q);
          end
        end else begin
          state_d = ST_OWNED;
          grant_d = grant_q;
          busy_d  = 1'b1;
          data_d  = dataIn[{own_q, 4'b0000} +: 16];
          point_d = pointIn[{own_q, 2'b00} +: 4];
          cnt_d   = dwell_done ? cnt_q : cnt_q + CW'(1);
        end
      end
      default: ;
    endcase

    if (take) begin
      state_d = ST_OWNED;
      own_d   = next_idx;
      ptr_d   = (next_idx == LAST_IDX) ? '0 : next_idx + IW'(1);
      cnt_d   = '0;
      grant_d = REQUESTERS'(1) << next_idx;
      busy_d  = 1'b1;
      data_d  = dataIn[{next_idx, 4'b0000} +: 16];
      point_d = pointIn[{next_idx, 2'b00} +: 4];
    end
  end

  assign grant       = grant_q;
  assign data        = data_q;
  assign pointEnable = point_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter (4 requesters, dwell of 4 cycles).
module tb_display_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      request = '0;
  logic [16*N-1:0]   dataIn = '0;
  logic [4*N-1:0]    pointIn = '0;
  logic [N-1:0]      grant;
  logic [15:0]       data;
  logic [3:0]        pointEnable;
  logic              busy;

  display_arbiter #(
    .REQUESTERS  (N),
    .DWELL_CYCLES(DW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .request    (request),
    .dataIn     (dataIn),
    .pointIn    (pointIn),
    .grant      (grant),
    .data       (data),
    .pointEnable(pointEnable),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: owner index (-1 = idle), rotation pointer, cycles held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First requester in rotation order starting at m_ptr, skipping excl.
  function automatic int first_from(input logic [N-1:0] r, input int excl);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (j != excl && r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_grant(input int j);
    m_owner = j;
    m_ptr   = (j + 1) % N;
    m_held  = 0;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
  endtask

  // Apply the arbitration rules for one rising edge.
  task automatic model_edge();
    int j;
    if (reset) begin
      model_reset();
    end else if (m_owner < 0) begin
      j = first_from(request, -1);
      if (j >= 0) model_grant(j);
    end else if (!request[m_owner]) begin
      j = first_from(request, m_owner);
      if (j >= 0) model_grant(j);
      else m_owner = -1;
    end else if (m_held >= DW - 1) begin
      j = first_from(request, m_owner);
      if (j >= 0) model_grant(j);
    end else begin
      m_held++;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    logic [15:0]  ed;
    logic [3:0]   ep;
    eg = '0;
    ed = '0;
    ep = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ed = dataIn[16*m_owner +: 16];
      ep = pointIn[4*m_owner +: 4];
    end
    check("grant", 32'(grant), 32'(eg));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("data", 32'(data), 32'(ed));
    check("point", 32'(pointEnable), 32'(ep));
    check("onehot", 32'($onehot0(grant)), 32'd1);
    check("granted_req", 32'(grant & ~request), 32'd0);
  endtask

  // One clock: present inputs, take the edge, update the model, compare.
  task automatic step(input logic [N-1:0] r);
    request = r;
    dataIn  = {$urandom, $urandom};
    pointIn = 16'($urandom);
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  // Reset pulse between edges; outputs must clear before the next edge.
  task automatic reset_pulse();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_point", 32'(pointEnable), 32'd0);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0] r;

    #1 reset = 1'b1;
    #1;
    check("init_grant", 32'(grant), 32'd0);
    check("init_busy", 32'(busy), 32'd0);
    check("init_data", 32'(data), 32'd0);
    step(4'b1111);          // ignored while reset is high
    step(4'b1010);
    reset = 1'b0;

    // Lowest requester after reset, ptr=0 search.
    step(4'b1010);
    check("first_grant", 32'(grant), 32'h2);
    // Owner 1 holds for the dwell, then requester 3 takes over.
    for (int i = 0; i < 3; i++) begin
      step(4'b1010);
      check("dwell_hold", 32'(grant), 32'h2);
    end
    step(4'b1010);
    check("dwell_handover", 32'(grant), 32'h8);
    // Owner 3 drops; wrap to requester 0 without waiting for dwell.
    step(4'b0101);
    check("drop_wrap", 32'(grant), 32'h1);
    // Sole owner drops: back to idle.
    step(4'b0001);
    step(4'b0000);
    check("idle_grant", 32'(grant), 32'd0);
    check("idle_data", 32'(data), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    // Reset in the middle of an ownership.
    step(4'b0100);
    check("pre_reset", 32'(grant), 32'h4);
    reset_pulse();
    step(4'b1111);
    check("post_reset", 32'(grant), 32'h1);
    // Full contention: rotation every DW cycles.
    for (int i = 0; i < 40; i++) step(4'b1111);

    // Randomized requests with slow-changing levels.
    r = 4'b0000;
    for (int i = 0; i < 500; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      step(r);
      if ($urandom_range(99) == 0) reset_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter REQUESTERS, default 4; number of requesters sharing the display, legal range 2..8.
REQ-002 SHALL have parameter DWELL_CYCLES, default 50000000; minimum clock cycles an owner holds the display against contention, legal range >= 1.
REQ-003 SHALL have port clock, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port request, input, REQUESTERS, bit i high = requester i wants the display (level, held for the whole use).
REQ-006 SHALL have port dataIn, input, 16*REQUESTERS, requester i hex digits at bits [16i+15:16i].
REQ-007 SHALL have port pointIn, input, 4*REQUESTERS, requester i decimal-point mask at bits [4i+3:4i].
REQ-008 SHALL have port grant, output, REQUESTERS, one-hot owner, or all-zero when idle.
REQ-009 SHALL have port data, output, 16, registered digit data for the seven-segment controller.
REQ-010 SHALL have port pointEnable, output, 4, registered decimal-point mask for the seven-segment controller.
REQ-011 SHALL have port busy, output, 1, high while any requester owns the display.

Function
REQ-012 SHALL implement two states: IDLE (grant=0, busy=0) and OWNED (grant one-hot, busy=1).
REQ-013 SHALL keep a round-robin pointer ptr (0..REQUESTERS-1); search order ptr, ptr+1, ... wrapping modulo REQUESTERS.
REQ-014 SHALL, in IDLE with any request bit high at an edge, enter OWNED with grant to first requesting index in search order at that edge (grant visible 1 cycle after request).
REQ-015 SHALL, on every grant to index i, set ptr to (i+1) mod REQUESTERS, wrapping from REQUESTERS-1 to 0.
REQ-016 SHALL keep a dwell counter cleared to 0 on every grant edge, incrementing each OWNED cycle, saturating at DWELL_CYCLES-1; dwellDone = (counter == DWELL_CYCLES-1).
REQ-017 SHALL, in OWNED with owner request high, dwellDone high and any other request high, hand over to next requester in search order (owner excluded) on the same edge, no idle cycle.
REQ-018 SHALL, in OWNED with owner request high and either dwellDone low or no other request, keep current grant.
REQ-019 SHALL, when owner request is low at an edge, hand over immediately (ignoring dwell) to next requester in search order if any other request is high, else go to IDLE.
REQ-020 SHALL never assert more than one grant bit, nor grant a requester whose request is low at the granting edge.
REQ-021 SHALL register data/pointEnable each edge from the slice of the requester being granted at that edge, so data and grant change on the same edge; owner input changes appear 1 cycle later.
REQ-022 SHALL drive data=16'h0000 and pointEnable=4'b0000 in IDLE.
REQ-023 SHALL, with DWELL_CYCLES=1, allow handover on the edge after a grant when contention exists.

Reset
REQ-024 SHALL, on reset asserted, immediately force IDLE, grant=0, busy=0, data=0, pointEnable=0, ptr=0, dwell counter=0, regardless of clock.
REQ-025 SHALL, on reset mid-ownership, drop the grant asynchronously and re-arbitrate from ptr=0 on the first edge after reset deasserts.
REQ-026 SHALL ignore all requests while reset is high.

Verification (REQUESTERS=4, DWELL_CYCLES=4 unless stated)
REQ-027 SHALL cover: reset; request=4'b1010 at edge 0 -> grant=4'b0010 at edge 1, data=dataIn[31:16], ptr=2, busy=1.
REQ-028 SHALL cover: owner 1 held, request 3 raised at grant+1 -> grant stays 4'b0010 until counter reaches 3, then grant=4'b1000 at next edge, ptr=0.
REQ-029 SHALL cover: owner 3 (ptr=0) drops request with requests 0 and 2 high -> grant=4'b0001 next edge without dwell; wrap-around checked.
REQ-030 SHALL cover: sole owner drops request -> grant=0, busy=0, data=16'h0000, pointEnable=0 next edge.
REQ-031 SHALL cover: reset pulse mid-ownership between clock edges -> grant=0 before next edge; after release with request=4'b1111 -> grant=4'b0001.
REQ-032 SHALL cover: all four requesting continuously for 40 cycles -> grants rotate 0,1,2,3,0 each after exactly 4 cycles owned, one-hot checked every cycle.
